// File: rtl/ring_buffer_reader.sv
// Command ring-buffer consumer: polls the producer's write pointer, fetches pending
// entries, hands them to the interpreter and writes the advanced read pointer back.
module ring_buffer_reader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BUF_BASE   = 16,
  parameter int unsigned RPTR_ADDR  = 1,
  parameter int unsigned WPTR_ADDR  = 2,
  parameter int unsigned POLL_DELAY = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_DataOut,
  input  logic              mem_done,
  input  logic              exec_done,
  output logic              mem_enable,
  output logic              mem_readWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_DataWrite,
  output logic [DATA_W-1:0] dataToInterpreter,
  output logic              exec_sample,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [PTR_W:0]    level,
  output logic              ptr_error
);

  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (POLL_DELAY > 1) ? $clog2(POLL_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WPTR, S_CHECK, S_RD_ENTRY, S_WAIT_EXEC, S_WR_RPTR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               en_q, en_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sample_q, sample_d;
  logic               err_q, err_d;

  logic               acc_done;
  logic               wptr_bad;
  logic               exec_ok;
  logic [PTR_W-1:0]   rd_next;

  // A mem_done only completes an access while our request is actually up.
  assign acc_done = en_q & mem_done;
  assign wptr_bad = (mem_DataOut >= DATA_W'(DEPTH));
  assign exec_ok  = exec_done & ~sample_q;
  assign rd_next  = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cnt_q == CNT_W'(POLL_DELAY - 1)) state_d = S_RD_WPTR;
      S_RD_WPTR:   if (acc_done) state_d = wptr_bad ? S_IDLE : S_CHECK;
      S_CHECK:     state_d = (rd_ptr_q == wptr_q) ? S_IDLE : S_RD_ENTRY;
      S_RD_ENTRY:  if (acc_done) state_d = S_WAIT_EXEC;
      S_WAIT_EXEC: if (exec_ok) state_d = S_WR_RPTR;
      S_WR_RPTR:   if (acc_done) state_d = (rd_ptr_q != wptr_q) ? S_RD_ENTRY : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Each access state raises its request on entry, so mem_enable is low for at
  // least one cycle between back-to-back accesses.
  always_comb begin
    cnt_d    = '0;
    wptr_d   = wptr_q;
    rd_ptr_d = rd_ptr_q;
    en_d     = en_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    sample_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != CNT_W'(POLL_DELAY - 1)) cnt_d = cnt_q + CNT_W'(1);
      end
      S_RD_WPTR: begin
        if (!en_q) begin
          en_d   = 1'b1;
          rw_d   = 1'b1;
          addr_d = ADDR_W'(WPTR_ADDR);
        end else if (mem_done) begin
          en_d = 1'b0;
          if (wptr_bad) err_d = 1'b1;
          else          wptr_d = mem_DataOut[PTR_W-1:0];
        end
      end
      S_RD_ENTRY: begin
        if (!en_q) begin
          en_d   = 1'b1;
          rw_d   = 1'b1;
          addr_d = ADDR_W'(BUF_BASE) + ADDR_W'(rd_ptr_q);
        end else if (mem_done) begin
          en_d     = 1'b0;
          data_d   = mem_DataOut;
          sample_d = 1'b1;
        end
      end
      S_WAIT_EXEC: begin
        if (exec_ok) rd_ptr_d = rd_next;
      end
      S_WR_RPTR: begin
        if (!en_q) begin
          en_d    = 1'b1;
          rw_d    = 1'b0;
          addr_d  = ADDR_W'(RPTR_ADDR);
          wdata_d = DATA_W'(rd_ptr_q);
        end else if (mem_done) begin
          en_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      wptr_q   <= '0;
      rd_ptr_q <= '0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rd_ptr_q <= rd_ptr_d;
      en_q     <= en_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      err_q    <= err_d;
    end
  end

  // Pending entries, wrapping modulo DEPTH.
  always_comb begin
    if (wptr_q >= rd_ptr_q) level = LVL_W'(wptr_q) - LVL_W'(rd_ptr_q);
    else                    level = LVL_W'(wptr_q) + LVL_W'(DEPTH) - LVL_W'(rd_ptr_q);
  end

  assign mem_enable        = en_q;
  assign mem_readWrite     = rw_q;
  assign mem_address       = addr_q;
  assign mem_DataWrite     = wdata_q;
  assign dataToInterpreter = data_q;
  assign exec_sample       = sample_q;
  assign rd_ptr            = rd_ptr_q;
  assign ptr_error         = err_q;

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Scoreboard bench for ring_buffer_reader: a behavioural memory and interpreter
// drive the DUT; a negedge monitor pops expected reads, samples and write-backs.
module tb_ring_buffer_reader;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] mem_DataOut;
  logic              mem_done;
  logic              exec_done;
  logic              mem_enable;
  logic              mem_readWrite;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_DataWrite;
  logic [DATA_W-1:0] dataToInterpreter;
  logic              exec_sample;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    level;
  logic              ptr_error;

  ring_buffer_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BUF_BASE(16),
    .RPTR_ADDR(1), .WPTR_ADDR(2), .POLL_DELAY(4)
  ) dut (
    .clk(clk), .rst(rst), .mem_DataOut(mem_DataOut), .mem_done(mem_done),
    .exec_done(exec_done), .mem_enable(mem_enable), .mem_readWrite(mem_readWrite),
    .mem_address(mem_address), .mem_DataWrite(mem_DataWrite),
    .dataToInterpreter(dataToInterpreter), .exec_sample(exec_sample),
    .rd_ptr(rd_ptr), .level(level), .ptr_error(ptr_error)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_exec[$];
  logic [31:0] exp_wr[$];
  int lat       = 1;
  int npoll     = 0;
  int exec_mode = 0;
  int checks    = 0;
  int passes    = 0;
  bit done_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event not expected or not seen in time", name);
  endtask

  // Memory: answers each request with mem_done after lat extra cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_done = 1'b0;
    mem_DataOut = '0;
    forever begin
      @(posedge clk); #1;
      mem_done = 1'b0;
      if (rst === 1'b1 && mem_enable === 1'b1) begin
        if (wcnt >= lat) begin
          mem_done = 1'b1;
          wcnt = 0;
          if (mem_readWrite) mem_DataOut = mem[int'(mem_address) & 63];
          else               mem[int'(mem_address) & 63] = mem_DataWrite;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Interpreter: 0 = pulse 3 cycles after sample, 1 = held high,
  // 2 = pulse coinciding with sample then again 6 cycles later.
  initial begin
    int cnt;
    cnt = 0;
    exec_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      exec_done = 1'b0;
      if (exec_mode == 1) begin
        exec_done = 1'b1;
      end else begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) exec_done = 1'b1;
        end
        if (exec_sample) begin
          cnt = (exec_mode == 2) ? 6 : 3;
          if (exec_mode == 2) exec_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes an access or samples.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_enable && mem_done) begin
        if (mem_readWrite) begin
          if (mem_address == ADDR_W'(2)) npoll++;
          else if (exp_rd.size() == 0) fail_now("unexpected_entry_read");
          else check("entry_addr", 64'(mem_address), 64'(exp_rd.pop_front()));
        end else begin
          if (exp_wr.size() == 0) fail_now("unexpected_writeback");
          else begin
            check("wb_addr", 64'(mem_address), 64'd1);
            check("wb_data", 64'(mem_DataWrite), 64'(exp_wr.pop_front()));
            check("wb_after_exec_done", 64'(done_seen), 64'd1);
          end
        end
      end
      if (exec_sample) begin
        done_seen = 1'b0;
        if (exp_exec.size() == 0) fail_now("unexpected_exec_sample");
        else check("entry_data", 64'(dataToInterpreter), 64'(exp_exec.pop_front()));
      end else if (exec_done) begin
        done_seen = 1'b1;
      end
    end
  end

  task automatic push_entry(input int addr, input logic [31:0] val, input int wb);
    mem[addr] = val;
    exp_rd.push_back(32'(addr));
    exp_exec.push_back(val);
    exp_wr.push_back(32'(wb));
  endtask

  task automatic wait_sample(input int maxc, input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!exec_sample && n < maxc);
    if (!exec_sample) fail_now(name);
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while ((exp_rd.size() + exp_exec.size() + exp_wr.size()) != 0 && n < maxc) begin
      @(negedge clk); n++;
    end
    if ((exp_rd.size() + exp_exec.size() + exp_wr.size()) != 0) fail_now(name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int p0;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_enable", 64'(mem_enable), 64'd0);
    check("rst_exec_sample", 64'(exec_sample), 64'd0);
    check("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ptr_error", 64'(ptr_error), 64'd0);
    check("rst_data", 64'(dataToInterpreter), 64'd0);
    check("rst_address", 64'(mem_address), 64'd0);
    rst = 1'b1;

    // Empty ring: repeated polls, nothing consumed.
    repeat (40) @(negedge clk);
    check("t1_polls_seen", 64'(npoll >= 3), 64'd1);
    check("t1_level", 64'(level), 64'd0);
    check("t1_rd_ptr", 64'(rd_ptr), 64'd0);

    // Three entries drained on one poll.
    for (int i = 0; i < 3; i++) push_entry(16 + i, 32'hA000_0000 + 32'(i), i + 1);
    mem[2] = 32'd3;
    wait_sample(100, "t2_first_sample");
    p0 = npoll;
    wait_drain(200, "t2_drain");
    check("t2_no_repoll", 64'(npoll), 64'(p0));
    check("t2_rd_ptr", 64'(rd_ptr), 64'd3);
    check("t2_level", 64'(level), 64'd0);

    // Advance to rd_ptr=14, then wrap.
    for (int i = 3; i < 14; i++) push_entry(16 + i, 32'hB000_0000 + 32'(i), i + 1);
    mem[2] = 32'd14;
    wait_drain(600, "t3_stage_drain");
    check("t3_stage_rd_ptr", 64'(rd_ptr), 64'd14);
    push_entry(30, 32'hC0DE_0001, 15);
    push_entry(31, 32'hC0DE_0002, 0);
    push_entry(16, 32'hC0DE_0003, 1);
    mem[2] = 32'd1;
    wait_sample(100, "t3_first_sample");
    check("t3_level_3", 64'(level), 64'd3);
    wait_drain(200, "t3_drain");
    check("t3_level_0", 64'(level), 64'd0);
    check("t3_rd_ptr", 64'(rd_ptr), 64'd1);

    // Corrupt write pointer after a fresh reset.
    mem[2] = 32'd0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t4_rd_ptr_reset", 64'(rd_ptr), 64'd0);
    mem[2] = 32'd20;
    n = 0;
    while (!ptr_error && n < 100) begin @(negedge clk); n++; end
    check("t4_ptr_error", 64'(ptr_error), 64'd1);
    repeat (20) @(negedge clk);
    check("t4_rd_ptr_hold", 64'(rd_ptr), 64'd0);
    check("t4_level_hold", 64'(level), 64'd0);
    push_entry(16, 32'hD000_0000, 1);
    push_entry(17, 32'hD000_0001, 2);
    mem[2] = 32'd2;
    wait_drain(200, "t4_drain");
    check("t4_ptr_error_sticky", 64'(ptr_error), 64'd1);
    check("t4_rd_ptr", 64'(rd_ptr), 64'd2);

    // exec_done held high, then coinciding with exec_sample.
    exec_mode = 1;
    push_entry(18, 32'hE000_0000, 3);
    push_entry(19, 32'hE000_0001, 4);
    mem[2] = 32'd4;
    wait_drain(200, "t5_held_drain");
    check("t5_held_rd_ptr", 64'(rd_ptr), 64'd4);
    exec_mode = 2;
    push_entry(20, 32'hE000_0002, 5);
    push_entry(21, 32'hE000_0003, 6);
    mem[2] = 32'd6;
    wait_drain(200, "t5_coinc_drain");
    check("t5_coinc_rd_ptr", 64'(rd_ptr), 64'd6);
    exec_mode = 0;

    // Reset in the middle of an entry fetch.
    lat = 8;
    mem[22] = 32'hF000_0000;
    mem[2] = 32'd7;
    n = 0;
    while (!(mem_enable && mem_readWrite && mem_address == ADDR_W'(22)) && n < 200) begin
      @(negedge clk); n++;
    end
    check("t6_entry_fetch_seen", 64'(mem_address), 64'd22);
    rst = 1'b0;
    #1;
    check("t6_mem_enable", 64'(mem_enable), 64'd0);
    check("t6_rd_ptr", 64'(rd_ptr), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_exec_sample", 64'(exec_sample), 64'd0);
    check("t6_data", 64'(dataToInterpreter), 64'd0);
    check("t6_ptr_error", 64'(ptr_error), 64'd0);
    mem[2] = 32'd0;
    lat = 1;
    @(negedge clk);
    rst = 1'b1;
    p0 = npoll;
    n = 0;
    while (npoll == p0 && n < 50) begin @(negedge clk); n++; end
    check("t6_poll_resumed", 64'(npoll > p0), 64'd1);

    repeat (5) @(negedge clk);
    check("end_exp_rd_empty", 64'(exp_rd.size()), 64'd0);
    check("end_exp_exec_empty", 64'(exp_exec.size()), 64'd0);
    check("end_exp_wr_empty", 64'(exp_wr.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
